// File: rtl/bpsk_demodulator_p.sv
// bpsk_demodulator_p: coherent BPSK demodulator.
// Correlates the DC-removed received sample against an external carrier
// reference. It integrates over one symbol period and decides the bit from the
// sign of the correlation. Symbol timing comes from an external peak detector
// through sync_valid/sync_offset.
// Optional feature: define BPSK_DEMOD_SOFT_EN to add the 8-bit soft-magnitude
// output bit_soft, which is registered together with bit_data.
module bpsk_demodulator_p #(
    parameter int DATA_WIDTH = 8,
    parameter int WAVELENGTH = 64,
    parameter int AMPLITUDE  = 2**(DATA_WIDTH-1),
    parameter int ACC_WIDTH  = 40
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic                  sample_valid,
    output logic [15:0]           phase,
    input  logic [DATA_WIDTH-1:0] ref_amp,
    input  logic                  sync_valid,
    input  logic [15:0]           sync_offset,
    output logic                  bit_data,
    output logic                  bit_valid,
    input  logic                  bit_ready,
    output logic                  locked,
    output logic                  overrun
`ifdef BPSK_DEMOD_SOFT_EN
    ,
    output logic [7:0]            bit_soft
`endif
);

    // Parameter sanity: the integrator must hold a full symbol of worst-case
    // products plus a sign bit, and the phase index must fit its 16-bit port.
    generate
        if (WAVELENGTH < 2) begin : g_bad_wavelength
            $error("bpsk_demodulator_p: WAVELENGTH must be at least 2");
        end
        if (WAVELENGTH > 65536) begin : g_big_wavelength
            $error("bpsk_demodulator_p: WAVELENGTH must fit the 16-bit phase index");
        end
        if (ACC_WIDTH < 2*DATA_WIDTH + $clog2(WAVELENGTH) + 1) begin : g_bad_acc
            $error("bpsk_demodulator_p: ACC_WIDTH too small for one symbol of products");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        TRACK = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [15:0] offset;
    logic [15:0] offset_next;
    logic [15:0] phase_next;
    logic [15:0] phase_inc;
    logic        phase_wrap;
    logic        sync_ok;
    logic        decide;

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic signed [ACC_WIDTH-1:0] centered;
    logic signed [ACC_WIDTH-1:0] ref_ext;
    logic signed [ACC_WIDTH-1:0] product;

    // A sync pulse is only meaningful when its offset lies inside one carrier period.
    assign sync_ok    = sync_valid && ({16'd0, sync_offset} < 32'(WAVELENGTH));
    assign phase_wrap = (phase == 16'(WAVELENGTH - 1));
    assign phase_inc  = phase_wrap ? 16'd0 : phase + 16'd1;

    // The sample is unsigned around AMPLITUDE and the reference is signed, so
    // both are widened to the integrator width before the multiply.
    assign centered = $signed(ACC_WIDTH'(sample)) - $signed(ACC_WIDTH'(AMPLITUDE));
    assign ref_ext  = ACC_WIDTH'($signed(ref_amp));
    assign product  = centered * ref_ext;
    assign acc_sum  = acc + product;

    assign locked = (state == TRACK);

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, phase, offset and integrator control. Nothing moves without
    // a valid sample. In TRACK a fresh sync wins over the end-of-symbol decision.
    always_comb begin
        state_next  = state;
        offset_next = offset;
        phase_next  = phase;
        acc_next    = acc;
        decide      = 1'b0;
        if (sample_valid) begin
            phase_next = phase_inc;
            case (state)
                IDLE: begin
                    acc_next = '0;
                    if (sync_ok) begin
                        state_next  = ALIGN;
                        offset_next = sync_offset;
                    end
                end
                ALIGN: begin
                    acc_next = '0;
                    if (sync_ok) begin
                        offset_next = sync_offset;
                    end else if (phase == offset) begin
                        phase_next = '0;
                        state_next = TRACK;
                    end
                end
                TRACK: begin
                    if (sync_ok) begin
                        state_next  = ALIGN;
                        offset_next = sync_offset;
                        acc_next    = '0;
                    end else if (phase_wrap) begin
                        acc_next = '0;
                        decide   = 1'b1;
                    end else begin
                        acc_next = acc_sum;
                    end
                end
                default: begin
                    state_next = IDLE;
                    acc_next   = '0;
                end
            endcase
        end
    end

    // Phase counter, latched symbol offset and correlation integrator.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase  <= '0;
            offset <= '0;
            acc    <= '0;
        end else begin
            phase  <= phase_next;
            offset <= offset_next;
            acc    <= acc_next;
        end
    end

    // Decided-bit register with valid/ready handshake. A new decision always
    // overwrites, and the sticky overrun flag records that a bit was lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_data  <= 1'b0;
            bit_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (decide) begin
                bit_data  <= acc_sum[ACC_WIDTH-1];
                bit_valid <= 1'b1;
                if (bit_valid && !bit_ready) begin
                    overrun <= 1'b1;
                end
            end else if (bit_valid && bit_ready) begin
                bit_valid <= 1'b0;
            end
        end
    end

`ifdef BPSK_DEMOD_SOFT_EN
    logic signed [8:0] soft_shift;
    logic        [8:0] soft_abs;
    logic        [7:0] soft_sat;

    // Soft confidence: the top nine bits of the correlation, folded to a
    // magnitude. The single value 256 (from -256) saturates to 255.
    always_comb begin
        soft_shift = 9'(acc_sum >>> (ACC_WIDTH - 9));
        soft_abs   = soft_shift[8] ? 9'(-soft_shift) : 9'(soft_shift);
        soft_sat   = soft_abs[8] ? 8'hFF : soft_abs[7:0];
    end

    // Soft value is captured with exactly the same timing as bit_data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_soft <= '0;
        end else if (decide) begin
            bit_soft <= soft_sat;
        end
    end
`endif

endmodule
